// File: rtl/pin_collector.sv
// pin_collector: gathers up to ten asynchronous input pins into one registered bus.
// Each pin passes through a two-flop synchronizer. The synchronized vector is optionally
// debounced, and per-bit rise/fall change events are reported over a valid/ready handshake.
//
// Build option: define PIN_COLLECTOR_DEBOUNCE_EN to include the cand/cnt debounce stage.
// Without it, every change at the synchronizer output is accepted on the next edge, and
// DEBOUNCE is ignored.
//
// Reset is synchronous and active-low (rstn sampled on the rising edge of clk).

module pin_collector #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    input  logic             i4,
    input  logic             i5,
    input  logic             i6,
    input  logic             i7,
    input  logic             i8,
    input  logic             i9,
    output logic [WIDTH-1:0] o,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_rise,
    output logic [WIDTH-1:0] evt_fall
);

    // Elaboration-time guard on legal parameter ranges.
    if (WIDTH < 1 || WIDTH > 10) begin : g_bad_width
        $error("pin_collector: WIDTH must be 1..10");
    end
    if (DEBOUNCE < 2 || DEBOUNCE > 65536) begin : g_bad_debounce
        $error("pin_collector: DEBOUNCE must be 2..65536");
    end

    // Pins at or above WIDTH are dropped here.
    logic [9:0]       pins_all;
    logic [WIDTH-1:0] pins;

    assign pins_all = {i9, i8, i7, i6, i5, i4, i3, i2, i1, i0};
    assign pins     = pins_all[WIDTH-1:0];

    // Synchronizer and output state.
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             valid_q, valid_d;

    // accept: a new vector is taken into o on this edge; new_val is that vector.
    logic             accept;
    logic [WIDTH-1:0] new_val;
    logic             handshake;

`ifdef PIN_COLLECTOR_DEBOUNCE_EN
    localparam int unsigned CntW   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Debounce next-state: any difference restarts the count, otherwise count and saturate.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign accept  = (cnt_q == CntMax) && (s2_q == cand_q) && (cand_q != o_q);
    assign new_val = cand_q;
`else
    // No debounce: o tracks s2 one edge later.
    assign accept  = (s2_q != o_q);
    assign new_val = s2_q;
`endif

    assign handshake = valid_q && evt_ready;

    // Output and event-mask next-state. A handshake clears the masks first, so a
    // simultaneous accept leaves only the fresh change bits and keeps valid high.
    always_comb begin
        o_d     = o_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        valid_d = valid_q;
        if (handshake) begin
            rise_d  = '0;
            fall_d  = '0;
            valid_d = 1'b0;
        end
        if (accept) begin
            o_d     = new_val;
            rise_d  = rise_d | (new_val & ~o_q);
            fall_d  = fall_d | (~new_val & o_q);
            valid_d = 1'b1;
        end
    end

    // Synchronizer, output and event state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q    <= '0;
            s2_q    <= '0;
            o_q     <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= pins;
            s2_q    <= s1_q;
            o_q     <= o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            valid_q <= valid_d;
        end
    end

    assign o         = o_q;
    assign evt_valid = valid_q;
    assign evt_rise  = rise_q;
    assign evt_fall  = fall_q;

endmodule

// File: tb/tb_pin_collector.sv
// Self-checking bench for pin_collector: directed cases with literal expectations plus a
// randomized phase, all compared every cycle against a set-based behavioural model.

module tb_pin_collector;

    localparam int unsigned W = 10;
    localparam int unsigned D = 16;
`ifdef PIN_COLLECTOR_DEBOUNCE_EN
    localparam int unsigned LAT = D + 3;
`else
    localparam int unsigned LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [9:0]   pins;
    logic         ready;
    logic [W-1:0] o, evt_rise, evt_fall;
    logic         evt_valid;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pin_collector #(
        .WIDTH    (W),
        .DEBOUNCE (D)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i0        (pins[0]),
        .i1        (pins[1]),
        .i2        (pins[2]),
        .i3        (pins[3]),
        .i4        (pins[4]),
        .i5        (pins[5]),
        .i6        (pins[6]),
        .i7        (pins[7]),
        .i8        (pins[8]),
        .i9        (pins[9]),
        .o         (o),
        .evt_valid (evt_valid),
        .evt_ready (ready),
        .evt_rise  (evt_rise),
        .evt_fall  (evt_fall)
    );

    // Behavioural model: pins reach the comparison point two edges late; a value is taken
    // once it has been seen for D+1 consecutive edges (or immediately without debounce).
    logic [9:0] hist1, hist2;
    logic [9:0] stable_val;
    int         stable_run;
    logic [9:0] m_o, m_rise, m_fall;
    logic       m_valid;
    bit         seen_reset = 0;

    always @(posedge clk) begin
        logic [9:0] seen;
        logic       acc;
        if (!rstn) begin
            hist1 = '0; hist2 = '0;
            stable_val = '0; stable_run = 1;
            m_o = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0;
            seen_reset = 1;
        end else begin
            seen = hist2;
`ifdef PIN_COLLECTOR_DEBOUNCE_EN
            if (seen == stable_val) begin
                if (stable_run <= int'(D)) stable_run++;
            end else begin
                stable_val = seen;
                stable_run = 1;
            end
            acc = (stable_run >= int'(D) + 1) && (stable_val != m_o);
`else
            stable_val = seen;
            acc = (seen != m_o);
`endif
            if (m_valid && ready) begin
                m_rise = '0; m_fall = '0; m_valid = 1'b0;
            end
            if (acc) begin
                m_rise  = m_rise | (stable_val & ~m_o);
                m_fall  = m_fall | (~stable_val & m_o);
                m_valid = 1'b1;
                m_o     = stable_val;
            end
            hist2 = hist1;
            hist1 = pins;
        end
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (seen_reset) begin
            check("model_o",     o,                m_o);
            check("model_valid", {9'b0, evt_valid}, {9'b0, m_valid});
            check("model_rise",  evt_rise,         m_rise);
            check("model_fall",  evt_fall,         m_fall);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic ack();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    int hold;

    initial begin
        rstn  = 1'b0;
        ready = 1'b0;
        pins  = 10'h3FF;

        // Reset with all pins high.
        repeat (3) @(negedge clk);
        check("rst_o",     o, 10'h000);
        check("rst_valid", {9'b0, evt_valid}, 10'h000);
        check("rst_rise",  evt_rise, 10'h000);
        check("rst_fall",  evt_fall, 10'h000);
        #1 rstn = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("pre_accept_o", o, 10'h000);
        @(negedge clk);
        check("release_o",     o, 10'h3FF);
        check("release_rise",  evt_rise, 10'h3FF);
        check("release_valid", {9'b0, evt_valid}, 10'h001);
        #1 ready = 1'b1;
        @(negedge clk);
        check("ack_valid", {9'b0, evt_valid}, 10'h000);
        check("ack_rise",  evt_rise, 10'h000);
        #1 ready = 1'b0;

        // Return to all-low and clear.
        pins = 10'h000;
        steps(LAT + 2);
        ack();

        // Single rise on i3.
        pins[3] = 1'b1;
        repeat (LAT) @(negedge clk);
        check("i3_o",     o, 10'h008);
        check("i3_rise",  evt_rise, 10'h008);
        check("i3_fall",  evt_fall, 10'h000);
        check("i3_valid", {9'b0, evt_valid}, 10'h001);
        #1 ready = 1'b1;
        @(negedge clk);
        check("i3_ack_rise",  evt_rise, 10'h000);
        check("i3_ack_valid", {9'b0, evt_valid}, 10'h000);
        #1 ready = 1'b0;
        pins[3] = 1'b0;
        steps(LAT + 2);
        ack();

        // Short glitch on i5.
        pins[5] = 1'b1;
        steps(5);
        pins[5] = 1'b0;
        for (int k = 0; k < int'(LAT) + 10; k++) begin
            step();
`ifdef PIN_COLLECTOR_DEBOUNCE_EN
            check("glitch_o",     o, 10'h000);
            check("glitch_valid", {9'b0, evt_valid}, 10'h000);
`endif
        end
        ack();

        // Rise then fall before a handshake: both masks carry the bit.
        pins[0] = 1'b1;
        steps(LAT + 1);
        pins[0] = 1'b0;
        steps(LAT + 1);
        check("acc_rise",  evt_rise, 10'h001);
        check("acc_fall",  evt_fall, 10'h001);
        check("acc_o",     o, 10'h000);
        check("acc_valid", {9'b0, evt_valid}, 10'h001);
        ack();
        check("acc_clr_rise", evt_rise, 10'h000);
        check("acc_clr_fall", evt_fall, 10'h000);

        // Handshake on the same edge i7 is accepted, with i0 already pending.
        pins[0] = 1'b1;
        steps(LAT + 1);
        pins[7] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        check("sim_rise",  evt_rise, 10'h080);
        check("sim_fall",  evt_fall, 10'h000);
        check("sim_valid", {9'b0, evt_valid}, 10'h001);
        check("sim_o",     o, 10'h081);
        #1 ready = 1'b0;
        ack();

        // Reset in the middle of a pending i2 change.
        pins = 10'h004;
        steps(9);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_o",     o, 10'h000);
        check("midrst_valid", {9'b0, evt_valid}, 10'h000);
        check("midrst_rise",  evt_rise, 10'h000);
        #1 rstn = 1'b1;
        repeat (LAT) @(negedge clk);
        check("midrst_rel_o",    o, 10'h004);
        check("midrst_rel_rise", evt_rise, 10'h004);
        check("midrst_rel_fall", evt_fall, 10'h000);
        #1;

        // Randomized phase: varied hold times, random ready, occasional reset.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) pins = pins ^ (10'h001 << $urandom_range(0, 9));
                else pins = 10'($urandom);
                hold = $urandom_range(1, 2 * D + 4);
            end else begin
                hold--;
            end
            ready = ($urandom_range(0, 3) == 0);
            rstn  = ($urandom_range(0, 599) != 0);
            step();
        end
        rstn  = 1'b1;
        ready = 1'b0;
        steps(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pin_collector.md
# pin_collector

Gathers up to ten discrete input pins into one registered bus. Each pin is synchronized, the whole vector is optionally debounced, and per-bit rise/fall change events are reported over a valid/ready handshake. It is the inbound counterpart of the bus-to-pins splitter in the integration layer, and it sits between the top-level input pads and a GPIO/IRQ consumer.

## Interface
- WIDTH, 10, number of pins collected; legal 1..10; inputs i{n} with n >= WIDTH are ignored.
- DEBOUNCE, 16, cycles a synchronized vector must hold before it is accepted; legal 2..65536. Counter width is $clog2(DEBOUNCE).

- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- i0..i9  input  1 each  asynchronous pin inputs; bit n of the collected vector is i{n}.
- o  output  WIDTH  accepted, debounced pin vector.
- evt_valid  output  1  at least one accepted change is pending.
- evt_ready  input  1  consumer accepts pending events.
- evt_rise  output  WIDTH  sticky mask of bits that went 0->1 since the last handshake.
- evt_fall  output  WIDTH  sticky mask of bits that went 1->0 since the last handshake.

## Operation
- Sync: two flops per bit, s1 <= pins and s2 <= s1.
- Debounce, with the macro defined: registers cand[WIDTH] and cnt.
  - s2 != cand: cand <= s2, cnt <= 0.
  - Otherwise, cnt < DEBOUNCE-1: cnt <= cnt+1.
  - Otherwise, cnt saturates at DEBOUNCE-1.
  - Accept edge: cnt == DEBOUNCE-1 and s2 == cand and cand != o. Then o <= cand.
- Event masks on an accept edge:
  - rise accumulates cand & ~o.
  - fall accumulates ~cand & o.
  - evt_valid <= 1.
- Handshake edge (evt_valid && evt_ready):
  - Without a simultaneous accept: rise, fall and evt_valid are cleared.
  - With a simultaneous accept: rise and fall are loaded with only the new change bits, and evt_valid stays 1. No event is lost.
- Masks are sticky. They may gain bits while evt_valid=1 and evt_ready=0. The consumer samples the masks on the handshake edge.
- A bit that rises and then falls before a handshake shows 1 in both rise and fall.
- evt_valid=0 implies rise==0 and fall==0.
- evt_ready while evt_valid=0 has no effect.
- Reset (rstn=0 on an edge), taking effect on that edge:
  - s1, s2, cand, o, rise, fall cleared to 0; cnt cleared to 0; evt_valid cleared to 0.
  - Any debounce or event in progress is discarded.
  - Pins already high at reset release are reported as rise events once accepted.

## Timing
Latency is counted from a pin change that settles before edge 1.
- Edge 1: s1 updates. Edge 2: s2 updates.
- Macro defined:
  - Edge 3: cand loads, cnt=0.
  - Edge 2+DEBOUNCE: cnt reaches DEBOUNCE-1.
  - Edge 3+DEBOUNCE: o, the masks and evt_valid update.
  - With DEBOUNCE=16, the outputs are visible after edge 19.
- Macro undefined: o <= s2 every edge, so o, the masks and evt_valid are visible after edge 3.
- Glitches: any s2 toggle restarts the count. A pulse shorter than DEBOUNCE cycles at s2 never reaches o.
- Handshake takes effect on the edge it is sampled. evt_valid is low the following cycle unless a new accept occurred on that same edge.
- No combinational path from any input to any output.

## Configuration
- PIN_COLLECTOR_DEBOUNCE_EN defined: the cand/cnt debounce stage is present, with behaviour and latency as above.
- Undefined:
  - cand and cnt are absent and the DEBOUNCE parameter is ignored.
  - Every change at s2 is accepted on the next edge.
  - Event logic is otherwise identical.

## Test plan
- Reset: hold rstn=0 for 3 cycles with all pins=1 -> o=0, evt_valid=0, rise=fall=0 during reset. After release with DEBOUNCE=16 -> o=0x3FF and rise=0x3FF at edge 19.
- Single rise: i3 0->1, evt_ready=0 -> o=0x008, rise=0x008, fall=0, evt_valid=1 at edge 19. Then evt_ready=1 for 1 cycle -> masks=0, evt_valid=0.
- Glitch: i5 high for 5 cycles, then low -> o, evt_valid and the masks never change.
- Accumulate: i0 rises, then after acceptance i0 falls with evt_ready=0 -> rise=0x001, fall=0x001, o=0. A single handshake clears both.
- Simultaneous: evt_ready=1 on the same edge i7's rise is accepted -> after that edge rise=0x080, fall=0, evt_valid=1.
- Reset mid-debounce: rstn=0 at edge 10 of a pending i2 change -> cnt=0, o=0, evt_valid=0. Re-run with the macro undefined -> i2 change reaches o after edge 3.
